// File: rtl/main_control_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32 main control unit.
package ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8,
    FAULT    = 4'd9
  } state_t;

  localparam logic [OPC_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // States that block on the memory handshake and are covered by the timeout.
  function automatic logic is_wait_state(state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface main_control_fsm_if #(
  parameter int unsigned N = 4
);
  import ctrl_pkg::*;

  logic [OPC_W-1:0] opcode;
  logic             mem_ready;
  logic [N-3:0]     alu_op;
  logic [SEL_W-1:0] alu_src_a;
  logic [SEL_W-1:0] alu_src_b;
  logic [SEL_W-1:0] result_src;
  logic             adr_src;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic             reg_write;
  logic             fault;

  modport master (
    input  opcode, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           mem_read, mem_write, ir_write, pc_write, branch, reg_write, fault
  );

  modport slave (
    output opcode, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           mem_read, mem_write, ir_write, pc_write, branch, reg_write, fault
  );
endinterface

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state and flags when the limit is reached.
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_i,
  output logic at_limit_o
);
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so a state change never carries a stale count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (count_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == CNT_W'(WAIT_LIMIT));

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control unit for lw/sw/R-type/beq with memory-timeout fault detection.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  main_control_fsm_if.master   bus,
  output logic [STATE_W-1:0]   state_o
);
  localparam int unsigned ALU_W = N - 2;

  state_t state_q, state_d;
  logic   at_limit;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_d != state_q),
    .count_i    (is_wait_state(state_q) && !bus.mem_ready),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state; mem_ready wins over an expiring wait limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) state_d = DECODE;
        else if (at_limit) state_d = FAULT;
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FAULT;
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (bus.mem_ready) state_d = MEMWB;
        else if (at_limit) state_d = FAULT;
      end
      MEMWB:    state_d = FETCH;
      MEMWRITE: begin
        if (bus.mem_ready) state_d = FETCH;
        else if (at_limit) state_d = FAULT;
      end
      EXECR:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      FAULT:    state_d = FAULT;
      default:  state_d = FAULT;
    endcase
  end

  // Moore decode; only the FETCH load strobes look at mem_ready. Reset forces all quiet.
  always_comb begin
    bus.alu_op     = ALU_W'(ALUOP_ADD);
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.result_src = RES_ALUOUT;
    bus.adr_src    = ADR_PC;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.fault      = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_read   = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMADR: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMREAD: begin
          bus.adr_src  = ADR_RESULT;
          bus.mem_read = 1'b1;
        end
        MEMWB: begin
          bus.result_src = RES_MEMDATA;
          bus.reg_write  = 1'b1;
        end
        MEMWRITE: begin
          bus.adr_src   = ADR_RESULT;
          bus.mem_write = 1'b1;
        end
        EXECR: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_op    = ALU_W'(ALUOP_FUNCT);
        end
        ALUWB:   bus.reg_write = 1'b1;
        BEQ: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_op    = ALU_W'(ALUOP_SUB);
          bus.branch    = 1'b1;
        end
        FAULT:   bus.fault = 1'b1;
        default: bus.fault = 1'b1;
      endcase
    end
  end

  assign state_o = state_q;

endmodule
